// File: rtl/add_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : add_scheduler                                                   |
// | Desc   : Shares one pipelined FP32 adder between two requesters with     |
// |          round-robin grants, credit flow control and FWFT result FIFOs.  |
// |          Define ADD_SCHED_FIXED_PRIORITY_EN for fixed priority (req0).   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module add_scheduler #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_valid,
  output logic        req0_ready,
  output logic [31:0] res0_z,
  output logic        res0_valid,
  input  logic        res0_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [31:0] res1_z,
  output logic        res1_valid,
  input  logic        res1_ready,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  input  logic [31:0] adder_z
);

  localparam int            c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0] c_CRED_MAX = DEPTH[c_AW:0];

  logic [1:0]         w_req_valid, w_res_ready, w_elig, w_gnt, w_push, w_pop, w_res_valid;
  logic [1:0][31:0]   w_req_a, w_req_b, w_res_z;
  logic [31:0]        r_adder_a, r_adder_b;
  logic               r_iss_vld, r_iss_id;
  logic [LATENCY-1:0] r_tag_vld, r_tag_id;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_res_ready = {res1_ready, res0_ready};
  assign w_req_a     = {req1_a, req0_a};
  assign w_req_b     = {req1_b, req0_b};

`ifdef ADD_SCHED_FIXED_PRIORITY_EN
  assign w_gnt[0] = w_elig[0];
  assign w_gnt[1] = w_elig[1] & ~w_elig[0];
`else
  logic r_last;

  // Ties go to the requester that was not granted last.
  assign w_gnt[0] = w_elig[0] & (~w_elig[1] | r_last);
  assign w_gnt[1] = w_elig[1] & (~w_elig[0] | ~r_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|w_gnt) begin
      r_last <= w_gnt[1];
    end
  end
`endif

  // The issue register lines the tag up with the operands now on the adder.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_adder_a <= '0;
      r_adder_b <= '0;
      r_iss_vld <= 1'b0;
      r_iss_id  <= 1'b0;
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_iss_vld <= |w_gnt;
      r_iss_id  <= w_gnt[1];
      if (|w_gnt) begin
        r_adder_a <= w_req_a[w_gnt[1]];
        r_adder_b <= w_req_b[w_gnt[1]];
      end
      r_tag_vld[0] <= r_iss_vld;
      r_tag_id[0]  <= r_iss_id;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_req
    logic [31:0]   r_mem [DEPTH];
    logic [c_AW:0] r_wr, r_rd, r_cred;
    logic          w_empty;

    assign w_empty        = (r_wr == r_rd);
    assign w_elig[n]      = rst_n & w_req_valid[n] & (r_cred < c_CRED_MAX);
    assign w_push[n]      = r_tag_vld[LATENCY-1] & (r_tag_id[LATENCY-1] == 1'(n));
    assign w_pop[n]       = ~w_empty & w_res_ready[n];
    assign w_res_valid[n] = ~w_empty;
    assign w_res_z[n]     = w_empty ? '0 : r_mem[r_rd[c_AW-1:0]];

    always_ff @(posedge clk) begin
      if (w_push[n]) begin
        r_mem[r_wr[c_AW-1:0]] <= adder_z;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_wr   <= '0;
        r_rd   <= '0;
        r_cred <= '0;
      end else begin
        if (w_push[n]) r_wr <= r_wr + 1'b1;
        if (w_pop[n])  r_rd <= r_rd + 1'b1;
        case ({w_gnt[n], w_pop[n]})
          2'b10:   r_cred <= r_cred + 1'b1;
          2'b01:   r_cred <= r_cred - 1'b1;
          default: r_cred <= r_cred;
        endcase
      end
    end

`ifndef SYNTHESIS
    logic w_full;
    assign w_full = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);

    always_ff @(posedge clk) begin
      if (rst_n) begin
        assert (!(w_push[n] && w_full && !w_pop[n]));
      end
    end
`endif
  end

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign res0_valid = w_res_valid[0];
  assign res1_valid = w_res_valid[1];
  assign res0_z     = w_res_z[0];
  assign res1_z     = w_res_z[1];
  assign adder_a    = r_adder_a;
  assign adder_b    = r_adder_b;

endmodule
`default_nettype wire

// File: tb/tb_add_scheduler.sv
`default_nettype none
// Bench for add_scheduler: FP32 adder model, accept-time scoreboard, directed scenarios.
// Build with ADD_SCHED_FIXED_PRIORITY_EN to exercise the fixed-priority variant.
module tb_add_scheduler;

  localparam int LAT = 4;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_valid, req1_valid, res0_ready, res1_ready;
  logic        req0_ready, req1_ready, res0_valid, res1_valid;
  logic [31:0] res0_z, res1_z, adder_a, adder_b, adder_z;

  add_scheduler #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_a(req0_a), .req0_b(req0_b), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .res0_z(res0_z), .res0_valid(res0_valid), .res0_ready(res0_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .res1_z(res1_z), .res1_valid(res1_valid), .res1_ready(res1_ready),
    .adder_a(adder_a), .adder_b(adder_b), .adder_z(adder_z)
  );

  initial forever #5 clk = ~clk;

  // Single<->double conversion, exact for the normal values used here.
  function automatic logic [63:0] s2d(input logic [31:0] s);
    if (s[30:23] == 8'd0) return {s[31], 63'd0};
    return {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    logic [10:0] e;
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    real r;
    r = $bitstoreal(s2d(a)) + $bitstoreal(s2d(b));
    return d2s($realtobits(r));
  endfunction

  function automatic logic [31:0] itof(input int n);
    return d2s($realtobits(real'(n)));
  endfunction

  logic [31:0] m_pipe [LAT];
  always @(posedge clk) begin
    m_pipe[0] <= fadd(adder_a, adder_b);
    for (int i = 1; i < LAT; i++) m_pipe[i] <= m_pipe[i-1];
  end
  assign adder_z = m_pipe[LAT-1];

  int          n_checks = 0, n_errors = 0;
  int          n_acc0 = 0, n_acc1 = 0, n_pop0 = 0, n_pop1 = 0;
  logic        m_last = 1'b1;
  logic [31:0] q_exp0 [$];
  logic [31:0] q_exp1 [$];
  bit          acc_log [$];

`ifdef ADD_SCHED_FIXED_PRIORITY_EN
  bit fp_exp [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
`endif

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs are set at the falling edge; this settles, scores the cycle, and waits one clock.
  task automatic cycle();
    #1;
    if (!rst_n) begin
      q_exp0.delete();
      q_exp1.delete();
      m_last = 1'b1;
    end else begin
      check_eq("one_grant", req0_ready & req1_ready, 0);
      if (req0_valid && req0_ready) begin
        q_exp0.push_back(fadd(req0_a, req0_b)); acc_log.push_back(1'b0); n_acc0++; m_last = 1'b0;
      end
      if (req1_valid && req1_ready) begin
        q_exp1.push_back(fadd(req1_a, req1_b)); acc_log.push_back(1'b1); n_acc1++; m_last = 1'b1;
      end
      if (res0_valid && res0_ready) begin
        n_pop0++;
        if (q_exp0.size() == 0) check_eq("res0_unexpected", res0_z, 32'hxxxxxxxx);
        else check_eq("res0_z", res0_z, q_exp0.pop_front());
      end
      if (res1_valid && res1_ready) begin
        n_pop1++;
        if (q_exp1.size() == 0) check_eq("res1_unexpected", res1_z, 32'hxxxxxxxx);
        else check_eq("res1_z", res1_z, q_exp1.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    while ((q_exp0.size() != 0 || q_exp1.size() != 0 || res0_valid || res1_valid) && k < 60) begin
      cycle();
      k++;
    end
    check_eq("drain_done", q_exp0.size() + q_exp1.size(), 0);
  endtask

  task automatic single_issue(input string tag);
    int b0, cnt;
    b0 = n_acc0;
    req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_valid = 1'b1; res0_ready = 1'b1;
    cycle();
    req0_valid = 1'b0;
    check_eq({tag, "_accept"}, n_acc0 - b0, 1);
    cnt = 1;
    while (!res0_valid && cnt < 20) begin
      check_eq({tag, "_res1_quiet"}, res1_valid, 0);
      cycle();
      cnt++;
    end
    check_eq({tag, "_latency"}, cnt, LAT + 2);
    check_eq({tag, "_z"}, res0_z, 32'h40400000);
    drain();
  endtask

  initial begin
    int b0, b1, cnt;
    logic e;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = itof(5); req0_b = itof(6); req1_a = itof(7); req1_b = itof(8);
    res0_ready = 1'b0; res1_ready = 1'b0;
    repeat (3) cycle();
    check_eq("rst_req0_ready", req0_ready, 0);
    check_eq("rst_req1_ready", req1_ready, 0);
    check_eq("rst_res0_valid", res0_valid, 0);
    check_eq("rst_res1_valid", res1_valid, 0);
    check_eq("rst_res0_z", res0_z, 0);
    check_eq("rst_res1_z", res1_z, 0);
    check_eq("rst_adder_a", adder_a, 0);
    check_eq("rst_adder_b", adder_b, 0);
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res0_ready = 1'b1; res1_ready = 1'b1;
    cycle();

    single_issue("si");

    // Both requesters valid for 8 cycles.
    acc_log.delete();
    b0 = n_pop0; b1 = n_pop1;
    e = m_last;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_a = itof(n_acc0 + 1); req0_b = itof(100);
      req1_a = itof(n_acc1 + 1); req1_b = itof(200);
      cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("tie_count", acc_log.size(), 8);
    for (int i = 0; i < acc_log.size() && i < 8; i++) begin
`ifdef ADD_SCHED_FIXED_PRIORITY_EN
      check_eq("fp_order", acc_log[i], fp_exp[i]);
`else
      check_eq("rr_order", acc_log[i], e ^ (i[0] == 1'b0));
`endif
    end
    drain();
`ifndef ADD_SCHED_FIXED_PRIORITY_EN
    check_eq("rr_pops0", n_pop0 - b0, 4);
    check_eq("rr_pops1", n_pop1 - b1, 4);
`endif

    // Credit stall on requester 0.
    res0_ready = 1'b0;
    b0 = n_acc0;
    req0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_a = itof(n_acc0 - b0 + 1); req0_b = itof(10);
      cycle();
    end
    check_eq("cs_accepts", n_acc0 - b0, DEP);
    for (int i = 0; i < 6; i++) begin
      check_eq("cs_stalled", req0_ready, 0);
      cycle();
    end
    check_eq("cs_res_valid", res0_valid, 1);
    res0_ready = 1'b1;
    cycle();
    res0_ready = 1'b0;
    b0 = n_acc0;
    repeat (4) cycle();
    check_eq("cs_one_more", n_acc0 - b0, 1);

    // Requester 1 streams while requester 0 sits at full credit.
    b1 = n_acc1;
    req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_valid = 1'b1; res1_ready = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      #1;
      check_eq("ci_req1_ready", req1_ready, 1);
      check_eq("ci_req0_stalled", req0_ready, 0);
      cycle();
    end
    req1_valid = 1'b0;
    check_eq("ci_accepts", n_acc1 - b1, DEP);
    cnt = 0;
    while (!res1_valid && cnt < 20) begin cycle(); cnt++; end
    check_eq("ci_z", res1_z, 32'h40000000);
    req0_valid = 1'b0;
    drain();

    // Reset with results in flight.
    b0 = n_acc0;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_a = itof(i + 1); req0_b = itof(7);
      cycle();
    end
    check_eq("rm_issues", n_acc0 - b0, 3);
    rst_n = 1'b0;
    #1;
    check_eq("rm_ready_in_rst", req0_ready, 0);
    cycle();
    rst_n = 1'b1; req0_valid = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      check_eq("rm_res0_quiet", res0_valid, 0);
      check_eq("rm_res1_quiet", res1_valid, 0);
      cycle();
    end
    single_issue("rm_fresh");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
